// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller: op codes,
// controller states, instruction field positions and default widths.
package alu_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int NREGS_DEFAULT = 8;

  // Instruction field positions: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb,
  // and for LDI the low nine bits [8:0] carry the immediate.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // ALU select value that makes the ALU output zero.
  localparam logic [3:0] SEL_ZERO = 4'd11;

  typedef enum logic [3:0] {
    OP_PASSA = 4'd0,
    OP_PASSB = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_DIV   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_NOP11 = 4'd11,
    OP_NOP12 = 4'd12,
    OP_NOP13 = 4'd13,
    OP_NOP14 = 4'd14,
    OP_LDI   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } issue_state_e;

  // Codes 11..14 do nothing: no writeback, no flag update.
  function automatic logic is_nop(alu_op_e op);
    return (op >= OP_NOP11) && (op <= OP_NOP14);
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file for the issue controller: two asynchronous operand read
// ports, one asynchronous debug read port, one synchronous write port.
// Asynchronous reset clears every entry.
module regfile_8x16
  import alu_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  output logic [DW-1:0]            rdata_a_o,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [DW-1:0]            rdata_b_o,
  input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
  output logic [DW-1:0]            dbg_data_o
);

  logic [DW-1:0] regs_q [NREGS];

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational ALU. Accepts one
// instruction per valid/ready handshake, reads operands, drives the ALU,
// captures its result and writes it back (IDLE -> READ -> EXEC -> WB).
// Optional feature macro: ALU_ISSUE_FLAGS_EN adds zero/negative flags of
// the last written value on outputs flag_z / flag_n.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              instr,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [3:0]               alu_sel,
  input  logic [DW-1:0]            alu_result,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_addr,
  output logic [DW-1:0]            wb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic                     flag_z,
  output logic                     flag_n
`endif
);

  localparam int AW = $clog2(NREGS);

  issue_state_e  state_q, state_d;
  logic [15:0]   instr_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [3:0]    alu_sel_q;
  logic [DW-1:0] result_q;

  alu_op_e       op;
  logic [AW-1:0] rd, ra, rb;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [DW-1:0] opa_d, opb_d;
  logic [3:0]    sel_d;
  logic          accept;
  logic          wr_en;

  // Field decode of the latched instruction.
  assign op = alu_op_e'(instr_q[OP_MSB:OP_LSB]);
  assign rd = instr_q[RD_MSB:RD_LSB];
  assign ra = instr_q[RA_MSB:RA_LSB];
  assign rb = instr_q[RB_MSB:RB_LSB];

  regfile_8x16 #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_en),
    .waddr_i    (rd),
    .wdata_i    (result_q),
    .raddr_a_i  (ra),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (rb),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake: only IDLE accepts; every instruction,
  // NOPs included, walks the full four-state sequence.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ALU drive values: register operands for ops 0-10, a zero-extended
  // immediate through PASSB for LDI, a zero-producing select for NOPs.
  always_comb begin
    opa_d = rdata_a;
    opb_d = rdata_b;
    sel_d = instr_q[OP_MSB:OP_LSB];
    if (op == OP_LDI) begin
      opa_d = '0;
      opb_d = {{(DW-IMM_W){1'b0}}, instr_q[IMM_MSB:IMM_LSB]};
      sel_d = OP_PASSB;
    end else if (is_nop(op)) begin
      sel_d = SEL_ZERO;
    end
  end

  // Instruction latch on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q <= instr;
    end
  end

  // ALU input registers: loaded leaving READ, held at all other times so
  // the ALU sees stable inputs throughout EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (state_q == S_READ) begin
      alu_a_q   <= opa_d;
      alu_b_q   <= opb_d;
      alu_sel_q <= sel_d;
    end
  end

  // Result capture at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_result;
    end
  end

  assign wr_en    = (state_q == S_WB) && !is_nop(op);

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign wb_valid = wr_en;
  assign wb_addr  = rd;
  assign wb_data  = result_q;

`ifdef ALU_ISSUE_FLAGS_EN
  logic flag_z_q, flag_n_q;

  // Flags follow each real writeback and hold across NOPs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (wr_en) begin
      flag_z_q <= (result_q == '0);
      flag_n_q <= result_q[DW-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed and random instructions, a
// stand-in ALU, a register-array reference model and a writeback scoreboard.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU (divide by zero returns all ones).
  always_comb begin
    case (alu_sel)
      4'd0:    alu_result = alu_a;
      4'd1:    alu_result = alu_b;
      4'd2:    alu_result = alu_a + alu_b;
      4'd3:    alu_result = alu_a - alu_b;
      4'd4:    alu_result = alu_a * alu_b;
      4'd5:    alu_result = (alu_b == 16'd0) ? 16'hFFFF : alu_a / alu_b;
      4'd6:    alu_result = alu_a & alu_b;
      4'd7:    alu_result = alu_a | alu_b;
      4'd8:    alu_result = alu_a ^ alu_b;
      4'd9:    alu_result = alu_a << alu_b;
      4'd10:   alu_result = alu_a >> alu_b;
      default: alu_result = 16'd0;
    endcase
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_t;

  wb_t         exp_q[$];
  logic [15:0] ref_regs [8];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          accept_cyc;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        efz = 1'b0, efn = 1'b0;
  logic        flag_pending = 1'b0;
`endif

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference semantics of a 16-bit unsigned op, computed from the op table.
  function automatic logic [15:0] ref_result(input int op, input int unsigned a, input int unsigned b);
    int unsigned r;
    case (op)
      0:  r = a;
      1:  r = b;
      2:  r = a + b;
      3:  r = a + 65536 - b;
      4:  r = a * b;
      5:  r = (b == 0) ? 65535 : a / b;
      6:  r = a & b;
      7:  r = a | b;
      8:  r = a ^ b;
      9:  r = (b >= 16) ? 0 : a * (1 << b);
      10: r = (b >= 16) ? 0 : a / (1 << b);
      15: r = b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
    logic [3:0] o; logic [2:0] d, a, b;
    o = op[3:0]; d = rd[2:0]; a = ra[2:0]; b = rb[2:0];
    return {o, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    logic [2:0] d; logic [8:0] i;
    d = rd[2:0]; i = imm[8:0];
    return {4'hF, d, i};
  endfunction

  // Writeback monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
`ifdef ALU_ISSUE_FLAGS_EN
      if (flag_pending) begin
        check("flag_z", {31'd0, flag_z}, {31'd0, efz});
        check("flag_n", {31'd0, flag_n}, {31'd0, efn});
        flag_pending = 1'b0;
      end
`endif
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wb_unexpected: actual addr=%0d data=%0d, required no writeback", wb_addr, wb_data);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_addr", {29'd0, wb_addr}, {29'd0, e.addr});
          check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
`ifdef ALU_ISSUE_FLAGS_EN
          efz = (e.data == 16'd0);
          efn = e.data[15];
          flag_pending = 1'b1;
`endif
        end
      end
    end
  end

  // Issue one instruction; checks occupancy and the ALU drive in EXEC.
  task automatic issue(input logic [15:0] ins, input bit keep);
    int op, rd, ra, rb, guard;
    int unsigned a, b;
    logic [3:0] esel;
    wb_t e;
    op = int'(ins[15:12]); rd = int'(ins[11:9]); ra = int'(ins[8:6]); rb = int'(ins[5:3]);
    @(negedge clk);
    instr = ins;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      in_valid = 1'b0;
      return;
    end
    if (op == 15) begin
      a = 0; b = int'(ins[8:0]); esel = 4'd1;
    end else begin
      a = ref_regs[ra]; b = ref_regs[rb];
      esel = (op <= 10) ? op[3:0] : 4'd11;
    end
    if (op <= 10 || op == 15) begin
      e.addr = rd[2:0];
      e.data = ref_result(op, a, b);
      exp_q.push_back(e);
      ref_regs[rd] = e.data;
    end
    @(posedge clk);
    accept_cyc = cycle;
    #1;
    if (!keep) in_valid = 1'b0;
    @(negedge clk);
    check("ready_read", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_exec", {31'd0, in_ready}, 32'd0);
    check("sel_exec", {28'd0, alu_sel}, {28'd0, esel});
    if (op <= 10 || op == 15) begin
      check("a_exec", {16'd0, alu_a}, a);
      check("b_exec", {16'd0, alu_b}, b);
    end
    @(negedge clk);
    check("ready_wb", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic dbg_check(input int r);
    dbg_addr = r[2:0];
    #1;
    check("dbg_data", {16'd0, dbg_data}, {16'd0, ref_regs[r]});
  endtask

  task automatic dbg_sweep();
    for (int r = 0; r < 8; r++) dbg_check(r);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2;
    rst = 1'b1; in_valid = 1'b0; instr = 16'd0; dbg_addr = 3'd0;
    for (int r = 0; r < 8; r++) ref_regs[r] = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
    check("rst_wb_data", {16'd0, wb_data}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    dbg_sweep();

    // Loads and arithmetic on r1=13, r2=6.
    issue(ldi(1, 13), 1'b0); @(negedge clk); dbg_check(1);
    check("r1_const", {16'd0, dbg_data}, 32'd13);
    issue(ldi(2, 6), 1'b0);  @(negedge clk); dbg_check(2);
    check("r2_const", {16'd0, dbg_data}, 32'd6);
    for (int op = 2; op <= 5; op++) begin
      issue(enc(op, 3, 1, 2), 1'b0); @(negedge clk); dbg_check(3);
    end
    for (int op = 6; op <= 10; op++) begin
      issue(enc(op, 4, 1, 2), 1'b0); @(negedge clk); dbg_check(4);
    end
    check("r4_shr_const", {16'd0, dbg_data}, 32'd0);

    // NOP: full occupancy, no writeback, registers untouched.
    issue(enc(12, 1, 1, 2), 1'b0);
    @(negedge clk); dbg_sweep();
    // SUB of a register with itself, rd also a source.
    issue(enc(3, 6, 1, 1), 1'b0);
    issue(enc(13, 6, 0, 0), 1'b0);
    issue(enc(2, 1, 1, 2), 1'b0);
    @(negedge clk); dbg_sweep();

    // in_valid held across three instructions: accepts every 4 cycles.
    issue(enc(2, 5, 1, 2), 1'b1); c0 = accept_cyc;
    issue(enc(7, 6, 1, 2), 1'b1); c1 = accept_cyc;
    issue(enc(8, 7, 1, 2), 1'b1); c2 = accept_cyc;
    in_valid = 1'b0;
    check("b2b_gap1", c1 - c0, 32'd4);
    check("b2b_gap2", c2 - c1, 32'd4);
    @(negedge clk); dbg_sweep();

    // Random instructions, including divide by zero and large shifts.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op == 15 || $urandom_range(0, 3) == 0)
        issue(ldi($urandom_range(0, 7), $urandom_range(0, 511)), 1'b0);
      else
        issue(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)), 1'b0);
    end
    @(negedge clk); dbg_sweep();

    // Reset during EXEC of ADD r5: aborted, no writeback, regs cleared.
    @(negedge clk);
    instr = enc(2, 5, 1, 2); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int r = 0; r < 8; r++) ref_regs[r] = 16'd0;
    check("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    dbg_check(5);
    repeat (4) @(negedge clk);
    dbg_sweep();
    issue(ldi(5, 300), 1'b0); @(negedge clk); dbg_check(5);
    repeat (2) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
